// File: rtl/sel_seq_pkg.sv
// Shared types and helpers for the channel-select scan sequencer.
package sel_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;
   localparam int   NUM_CH   = 8;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [2:0] lowest_set(input logic [NUM_CH-1:0] m);
      logic [2:0] res;
      res = 3'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         res = m[i] ? 3'(i) : res;
      end
      return res;
   endfunction

   function automatic logic [2:0] highest_set(input logic [NUM_CH-1:0] m);
      logic [2:0] res;
      res = 3'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         res = m[i] ? 3'(i) : res;
      end
      return res;
   endfunction

   // First channel visited by a scan in the given direction.
   function automatic logic [2:0] first_idx(input logic [NUM_CH-1:0] m, input logic d);
      return (d == DIR_DOWN) ? highest_set(m) : lowest_set(m);
   endfunction

endpackage

// File: rtl/sel_seq_next.sv
// Finds the next enabled channel after the current index in scan order,
// flagging when none remains (scans never wrap).
module sel_seq_next
   import sel_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [2:0]        idx,
   input  logic              dir,
   output logic [2:0]        nxt_idx,
   output logic              last
);

   logic [NUM_CH-1:0] above_s;
   logic [NUM_CH-1:0] below_s;

   // Enabled channels strictly above and strictly below the current index
   always_comb begin
      above_s = mask & (8'hFE << idx);
      below_s = mask & (8'h7F >> (3'd7 - idx));
   end

   // Pick the nearest candidate in the scan direction
   always_comb begin
      nxt_idx = idx;
      last    = 1'b1;
      if (dir == DIR_DOWN) begin
         nxt_idx = highest_set(below_s);
         last    = ~|below_s;
      end else begin
         nxt_idx = lowest_set(above_s);
         last    = ~|above_s;
      end
   end

endmodule

// File: rtl/sel_sequencer.sv
// Scans the enabled channels of a latched mask, holding each index for DWELL
// cycles, with hold/abort control and done/err status pulses.
module sel_sequencer
   import sel_seq_pkg::*;
#(
   parameter int DWELL = 1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       hold,
   input  logic       dir,
   input  logic [7:0] mask,
   output logic [2:0] sel,
   output logic       sel_valid,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

   state_t      state_r;
   state_t      next_state_s;
   logic [3:0]  cnt_r;
   logic [7:0]  mask_r;
   logic        dir_r;
   logic [2:0]  sel_r;
   logic        sel_valid_r;
   logic        busy_r;
   logic        done_r;
   logic        err_r;
   logic [2:0]  nxt_idx_s;
   logic        last_s;
   logic        accept_s;
   logic        expire_s;
   logic        advance_s;
   logic        busy_nxt_s;
   logic        done_nxt_s;
   logic        err_nxt_s;

   sel_seq_next u_next (
      .mask    (mask_r),
      .idx     (sel_r),
      .dir     (dir_r),
      .nxt_idx (nxt_idx_s),
      .last    (last_s)
   );

   // Qualifiers shared by the FSM and the datapath
   always_comb begin
      accept_s  = (state_r == ST_IDLE) && start && (mask != 8'h00);
      expire_s  = (cnt_r == DWELL_LAST);
      advance_s = (state_r == ST_SCAN) && !abort && !hold;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic; abort outranks hold
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = ST_SCAN;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (abort) begin
               next_state_s = ST_IDLE;
            end else if (advance_s && expire_s && last_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_SCAN;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // FSM output decode, computed one cycle ahead so the status flags are flops
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      err_nxt_s  = 1'b0;
      case (next_state_s)
         ST_SCAN: begin
            busy_nxt_s = 1'b1;
         end
         ST_DONE: begin
            done_nxt_s = 1'b1;
         end
         default: begin
            busy_nxt_s = 1'b0;
         end
      endcase
      if ((state_r == ST_IDLE) && start && (mask == 8'h00)) begin
         err_nxt_s = 1'b1;
      end else begin
         err_nxt_s = 1'b0;
      end
   end

   // Status output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         sel_valid_r <= busy_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         err_r       <= err_nxt_s;
      end
   end

   // Scan datapath: sel keeps its last value outside SCAN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_r <= 8'h00;
         dir_r  <= 1'b0;
         sel_r  <= 3'd0;
         cnt_r  <= 4'd0;
      end else if (accept_s) begin
         mask_r <= mask;
         dir_r  <= dir;
         sel_r  <= first_idx(mask, dir);
         cnt_r  <= 4'd0;
      end else if (advance_s) begin
         if (expire_s) begin
            cnt_r <= 4'd0;
            if (!last_s) begin
               sel_r <= nxt_idx_s;
            end
         end else begin
            cnt_r <= cnt_r + 4'd1;
         end
      end else if ((state_r == ST_SCAN) && abort) begin
         cnt_r <= 4'd0;
      end
   end

   assign sel       = sel_r;
   assign sel_valid = sel_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;

endmodule
